// File: rtl/mram_serial_bridge_if.sv
// rtl/mram_serial_bridge_if.sv - serial command and MRAM pin bundle for mram_serial_bridge
interface mram_serial_bridge_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    localparam int BE_W = DATA_W / 8;

    logic              s_valid;
    logic              s_bit;
    logic              busy;
    logic              done;
    logic              err;
    logic              sdo;
    logic              sdo_valid;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic [DATA_W-1:0] data_in;
    logic              chip_en;
    logic              write_en;
    logic              out_en;
    logic [BE_W-1:0]   byte_en;

    modport slave (
        input  s_valid, s_bit, data_in,
        output busy, done, err, sdo, sdo_valid, addr_out, data_out, data_oe,
               chip_en, write_en, out_en, byte_en
    );

    modport master (
        output s_valid, s_bit, data_in,
        input  busy, done, err, sdo, sdo_valid, addr_out, data_out, data_oe,
               chip_en, write_en, out_en, byte_en
    );
endinterface

// File: rtl/mram_serial_bridge.sv
// rtl/mram_serial_bridge.sv - serial frame to MRAM access bridge with serial read-back
// Optional mid-frame idle timeout: define MRAM_BRIDGE_TIMEOUT_EN.
module mram_serial_bridge #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int ACCESS_CYC = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mram_serial_bridge_if.slave  bus_io
);
    localparam int BE_W  = DATA_W / 8;
    localparam int MAX_A = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAX_B = (ACCESS_CYC > TIMEOUT) ? ACCESS_CYC : TIMEOUT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] BE_LAST   = CNT_W'(BE_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACCESS_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_ADDR, S_DATA, S_ACCESS, S_SHIFT} state_t;

    state_t             state_q;
    logic               op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BE_W-1:0]    mask_q, mask_d;
    logic [ADDR_W-1:0]  addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0]  data_sh_q, data_sh_d;
    logic [DATA_W-1:0]  rd_q;
    logic               busy_q, done_q, sdo_q, sdo_valid_q;
    logic [ADDR_W-1:0]  addr_out_q;
    logic [DATA_W-1:0]  data_out_q;
    logic [BE_W-1:0]    byte_en_q;
    logic               data_oe_q, chip_en_q, write_en_q, out_en_q;
    logic [BE_W:0]      mask_sh;
    logic [ADDR_W:0]    addr_sh;
    logic [DATA_W:0]    data_sh;
    logic               enter_acc;

    // Shadows shift right so the first (LSB) bit of each field lands at bit 0.
    always_comb begin
        mask_sh   = {bus_io.s_bit, mask_q} >> 1;
        addr_sh   = {bus_io.s_bit, addr_sh_q} >> 1;
        data_sh   = {bus_io.s_bit, data_sh_q} >> 1;
        mask_d    = mask_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        if (bus_io.s_valid) begin
            case (state_q)
                S_HDR:   mask_d    = mask_sh[BE_W-1:0];
                S_ADDR:  addr_sh_d = addr_sh[ADDR_W-1:0];
                S_DATA:  data_sh_d = data_sh[DATA_W-1:0];
                default: ;
            endcase
        end
        enter_acc = bus_io.s_valid &&
                    (((state_q == S_ADDR) && (cnt_q == ADDR_LAST) && !op_q) ||
                     ((state_q == S_DATA) && (cnt_q == DATA_LAST)));
    end

`ifdef MRAM_BRIDGE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] tmo_q;
    logic             err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 1'b0;
            cnt_q       <= '0;
            mask_q      <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            rd_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_valid_q <= 1'b0;
            addr_out_q  <= '0;
            data_out_q  <= '0;
            byte_en_q   <= '0;
            data_oe_q   <= 1'b0;
            chip_en_q   <= 1'b0;
            write_en_q  <= 1'b0;
            out_en_q    <= 1'b0;
`ifdef MRAM_BRIDGE_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            mask_q    <= mask_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            case (state_q)
                S_IDLE: if (bus_io.s_valid) begin
                    op_q    <= bus_io.s_bit;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_HDR;
                end
                S_HDR: if (bus_io.s_valid) begin
                    if (cnt_q == BE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_ADDR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ADDR: if (bus_io.s_valid) begin
                    if (cnt_q == ADDR_LAST) begin
                        cnt_q <= '0;
                        if (op_q) state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: if (bus_io.s_valid && (cnt_q != DATA_LAST)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_ACCESS: begin
                    if (cnt_q == ACC_LAST) begin
                        cnt_q      <= '0;
                        chip_en_q  <= 1'b0;
                        write_en_q <= 1'b0;
                        out_en_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        if (op_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            rd_q        <= bus_io.data_in;
                            sdo_q       <= bus_io.data_in[0];
                            sdo_valid_q <= 1'b1;
                            state_q     <= S_SHIFT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == DATA_LAST) begin
                        cnt_q       <= '0;
                        sdo_q       <= 1'b0;
                        sdo_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        rd_q  <= rd_q >> 1;
                        sdo_q <= rd_q[1];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Pins load only here so the MRAM bus never sees a half-shifted frame.
            if (enter_acc) begin
                state_q    <= S_ACCESS;
                cnt_q      <= '0;
                addr_out_q <= addr_sh_d;
                data_out_q <= data_sh_d;
                byte_en_q  <= mask_q;
                chip_en_q  <= 1'b1;
                write_en_q <= op_q;
                data_oe_q  <= op_q;
                out_en_q   <= !op_q;
            end
`ifdef MRAM_BRIDGE_TIMEOUT_EN
            err_q <= 1'b0;
            if ((state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_DATA)) begin
                if (bus_io.s_valid) begin
                    tmo_q <= '0;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_q   <= '0;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

`ifdef MRAM_BRIDGE_TIMEOUT_EN
    assign bus_io.err = err_q;
`else
    assign bus_io.err = 1'b0;
`endif
    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
    assign bus_io.sdo       = sdo_q;
    assign bus_io.sdo_valid = sdo_valid_q;
    assign bus_io.addr_out  = addr_out_q;
    assign bus_io.data_out  = data_out_q;
    assign bus_io.byte_en   = byte_en_q;
    assign bus_io.data_oe   = data_oe_q;
    assign bus_io.chip_en   = chip_en_q;
    assign bus_io.write_en  = write_en_q;
    assign bus_io.out_en    = out_en_q;
endmodule
